// File: rtl/sort_stream_tx_if.sv
// Handshake bundle between the frame transmitter, its upstream writer and
// the bubble-sort core it feeds.
interface sort_stream_tx_if;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       rx_valid;

  // Upstream writer / sorter side
  modport master (
    output wr_valid, wr_data, rx_valid,
    input  wr_ready, tx_valid, tx_data
  );

  // Transmitter side
  modport slave (
    input  wr_valid, wr_data, rx_valid,
    output wr_ready, tx_valid, tx_data
  );
endinterface

// File: rtl/sort_stream_tx.sv
// Frame transmitter for the bubble-sort core: buffers FRAME_LEN bytes,
// emits them as one gap-free burst, tracks the sorted result drain, then
// idles GAP_CYC cycles before accepting the next frame.
module sort_stream_tx #(
  parameter int unsigned FRAME_LEN = 10,
  parameter int unsigned GAP_CYC   = 2,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  sort_stream_tx_if.slave  bus,
  output logic             busy,
  output logic [7:0]       frame_cnt,
  output logic             err
);

  localparam int unsigned IW       = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [7:0]  LEN_B    = 8'(FRAME_LEN);
  localparam logic [7:0]  LAST_B   = 8'(FRAME_LEN - 1);
  localparam logic [7:0]  GAP_LAST = 8'(GAP_CYC - 1);
  localparam logic [15:0] TMO_W    = 16'(TIMEOUT);

  typedef enum logic [1:0] {FILL, SEND, WAIT, GAP} state_t;

  state_t      state, state_nxt;

  logic [7:0]  buf_mem [FRAME_LEN];
  logic [7:0]  wr_cnt;
  logic [7:0]  tx_idx;
  logic [7:0]  rx_cnt;
  logic [7:0]  gap_cnt;
  logic [15:0] tmo_cnt;
  logic [15:0] tmo_inc;
  logic        rx_q;
  logic        armed;

  logic        tx_valid_q;
  logic [7:0]  tx_data_q;

  logic        wr_ready;
  logic        wr_fire;
  logic        last_wr;
  logic        send_done;
  logic        done;
  logic        tmo_hit;
  logic        gap_done;

  logic        tx_valid_d;
  logic [7:0]  tx_data_d;
  logic        err_d;
  logic        frame_inc;

  // armed holds wr_ready low while reset is asserted; ready depends only on
  // registered state, never on wr_valid
  assign wr_ready  = armed && (state == FILL) && (wr_cnt < LEN_B);
  assign wr_fire   = wr_ready && bus.wr_valid;
  assign last_wr   = wr_fire && (wr_cnt == LAST_B);
  assign send_done = (state == SEND) && (tx_idx == LEN_B);
  // drain complete on the first falling edge of rx_valid seen inside WAIT
  assign done      = (state == WAIT) && rx_q && !bus.rx_valid;
  assign tmo_inc   = (tmo_cnt == 16'hFFFF) ? tmo_cnt : tmo_cnt + 16'd1;
  assign tmo_hit   = (state == WAIT) && (tmo_inc >= TMO_W);
  assign gap_done  = (state == GAP) && (gap_cnt == GAP_LAST);

  assign busy         = (state != FILL);
  assign bus.wr_ready = wr_ready;
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL:    if (last_wr)          state_nxt = SEND;
      SEND:    if (send_done)        state_nxt = WAIT;
      WAIT:    if (done || tmo_hit)  state_nxt = GAP;
      GAP:     if (gap_done)         state_nxt = FILL;
      default:                       state_nxt = FILL;
    endcase
  end

  // Next values of the registered outputs; the burst starts on the same edge
  // that accepts the last byte so tx_valid appears in the following cycle
  always_comb begin
    tx_valid_d = 1'b0;
    tx_data_d  = '0;
    err_d      = 1'b0;
    frame_inc  = 1'b0;
    unique case (state)
      FILL: begin
        if (last_wr) begin
          tx_valid_d = 1'b1;
          tx_data_d  = buf_mem[0];
        end
      end
      SEND: begin
        if (!send_done) begin
          tx_valid_d = 1'b1;
          tx_data_d  = buf_mem[tx_idx[IW-1:0]];
        end
      end
      WAIT: begin
        if (done) begin
          if (rx_cnt == LEN_B) frame_inc = 1'b1;
          else                 err_d     = 1'b1;
        end else if (tmo_hit) begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      err        <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      err        <= err_d;
      if (frame_inc) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // Frame counters; rx_valid is only observed while in WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed   <= 1'b0;
      wr_cnt  <= '0;
      tx_idx  <= '0;
      rx_cnt  <= '0;
      gap_cnt <= '0;
      tmo_cnt <= '0;
      rx_q    <= 1'b0;
    end else begin
      armed <= 1'b1;
      rx_q  <= 1'b0;
      unique case (state)
        FILL: begin
          if (wr_fire) wr_cnt <= wr_cnt + 8'd1;
          if (last_wr) tx_idx <= 8'd1;
        end
        SEND: begin
          if (!send_done) tx_idx <= tx_idx + 8'd1;
        end
        WAIT: begin
          rx_q    <= bus.rx_valid;
          tmo_cnt <= tmo_inc;
          if (bus.rx_valid && (rx_cnt != 8'hFF)) rx_cnt <= rx_cnt + 8'd1;
        end
        GAP: begin
          if (gap_done) begin
            wr_cnt  <= '0;
            tx_idx  <= '0;
            rx_cnt  <= '0;
            tmo_cnt <= '0;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // One-frame byte buffer, written in arrival order
  always_ff @(posedge clk) begin
    if (wr_fire) buf_mem[wr_cnt[IW-1:0]] <= bus.wr_data;
  end

endmodule

// File: tb/tb_sort_stream_tx.sv
// Directed bench for sort_stream_tx with a byte scoreboard on the tx burst.
module tb_sort_stream_tx;

  logic clk;
  logic rst_n;
  logic busy;
  logic [7:0] frame_cnt;
  logic err;

  sort_stream_tx_if bus ();

  sort_stream_tx #(
    .FRAME_LEN (10),
    .GAP_CYC   (2),
    .TIMEOUT   (20)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .frame_cnt (frame_cnt),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks   = 0;
  int         n_fail     = 0;
  int         err_cycles = 0;
  int         burst_len  = 0;
  bit         prev_tx    = 1'b0;
  logic [7:0] sb [$];

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction

  // tx burst monitor: every valid byte must match the next scoreboard entry
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_tx   = 1'b0;
      burst_len = 0;
    end else begin
      if (bus.tx_valid === 1'b1) begin
        burst_len++;
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) chk("tx_data", 32'(bus.tx_data), 32'(sb.pop_front()));
      end else if (prev_tx) begin
        chk("burst_len", 32'(burst_len), 32'd10);
        chk("tx_idle_data", 32'(bus.tx_data), 32'd0);
        burst_len = 0;
      end
      prev_tx = (bus.tx_valid === 1'b1);
      if (err === 1'b1) err_cycles++;
    end
  end

  // Writes one frame; returns at the first cycle of the burst
  task automatic fill_frame(input logic [7:0] d [10], input bit throttle);
    for (int i = 0; i < 10; i++) begin
      if (throttle && i > 0) begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'hEE;
        @(negedge clk);
      end
      chk("fill_ready", 32'(bus.wr_ready), 32'd1);
      bus.wr_valid = 1'b1;
      bus.wr_data  = d[i];
      sb.push_back(d[i]);
      @(negedge clk);
    end
    // throttled writer keeps offering junk that must not be accepted
    bus.wr_valid = throttle;
    bus.wr_data  = throttle ? 8'hEE : 8'h00;
    chk("ready_after_last", 32'(bus.wr_ready), 32'd0);
    chk("burst_start", 32'(bus.tx_valid), 32'd1);
    chk("busy_send", 32'(busy), 32'd1);
  endtask

  // Runs SEND, the sorter model in WAIT and the GAP; n_rx == 0 means no result
  task automatic finish_frame(input bit rx_in_send, input int n_rx,
                              input logic [7:0] exp_fc, input bit exp_err);
    int cnt;
    cnt = 0;
    if (rx_in_send) bus.rx_valid = 1'b1;
    while (bus.tx_valid === 1'b1 && cnt < 30) begin
      @(negedge clk);
      cnt++;
      if (cnt == 3) bus.rx_valid = 1'b0;
      chk("ready_send", 32'(bus.wr_ready), 32'd0);
    end
    chk("burst_cycles", 32'(cnt), 32'd10);
    if (n_rx > 0) begin
      bus.rx_valid = 1'b1;
      repeat (n_rx) begin
        @(negedge clk);
        chk("wait_err", 32'(err), 32'd0);
        chk("wait_busy", 32'(busy), 32'd1);
        chk("wait_ready", 32'(bus.wr_ready), 32'd0);
      end
      bus.rx_valid = 1'b0;
      @(negedge clk);
    end else begin
      cnt = 0;
      while (err !== 1'b1 && cnt < 40) begin
        @(negedge clk);
        cnt++;
      end
      chk("timeout_cycles", 32'(cnt), 32'd20);
    end
    chk("drain_err", 32'(err), 32'(exp_err));
    chk("drain_frame_cnt", 32'(frame_cnt), 32'(exp_fc));
    chk("gap1_busy", 32'(busy), 32'd1);
    chk("gap1_ready", 32'(bus.wr_ready), 32'd0);
    @(negedge clk);
    bus.wr_valid = 1'b0;
    bus.wr_data  = 8'h00;
    chk("err_one_cycle", 32'(err), 32'd0);
    chk("gap2_busy", 32'(busy), 32'd1);
    chk("gap2_ready", 32'(bus.wr_ready), 32'd0);
    @(negedge clk);
    chk("fill_busy", 32'(busy), 32'd0);
    chk("fill_ready_again", 32'(bus.wr_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] d [10];
    logic [7:0] fc;

    rst_n        = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = 8'h00;
    bus.rx_valid = 1'b0;
    fc           = 8'd0;

    repeat (2) @(negedge clk);
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.wr_ready), 32'd1);

    // Basic frame
    d = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd0, 8'd8, 8'd2, 8'd6, 8'd5, 8'd4};
    fill_frame(d, 1'b0);
    fc++;
    finish_frame(1'b0, 10, fc, 1'b0);

    // Throttled writer, sorter activity during SEND must be ignored
    d = '{8'h10, 8'hF1, 8'h22, 8'hD3, 8'h34, 8'hB5, 8'h46, 8'h97, 8'h58, 8'h79};
    fill_frame(d, 1'b1);
    fc++;
    finish_frame(1'b1, 10, fc, 1'b0);

    // Short result
    d = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hA9};
    fill_frame(d, 1'b0);
    finish_frame(1'b0, 9, fc, 1'b1);

    // Timeout: no result at all
    d = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'hFF, 8'h00};
    fill_frame(d, 1'b0);
    finish_frame(1'b0, 0, fc, 1'b1);

    // Reset after the 4th transmitted byte
    d = '{8'h55, 8'hAA, 8'h5A, 8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h66, 8'h77};
    fill_frame(d, 1'b0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_wr_ready", 32'(bus.wr_ready), 32'd0);
    sb.delete();
    fc = 8'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(bus.wr_ready), 32'd1);
    chk("rel_busy", 32'(busy), 32'd0);
    d = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd0, 8'd8, 8'd2, 8'd6, 8'd5, 8'd4};
    fill_frame(d, 1'b0);
    fc++;
    finish_frame(1'b0, 10, fc, 1'b0);

    // Back-to-back frames until frame_cnt wraps
    for (int f = 0; f < 255; f++) begin
      for (int i = 0; i < 10; i++) d[i] = 8'($urandom_range(0, 255));
      fill_frame(d, 1'b0);
      fc++;
      finish_frame(1'b0, 10, fc, 1'b0);
    end
    chk("frame_wrap", 32'(frame_cnt), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("err_total_cycles", 32'(err_cycles), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case a handshake never completes
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sort_stream_tx.md
Name: sort_stream_tx

Overview:
Frame transmitter that drives the in_valid/in_data input stream of the bubble-sort core. It collects FRAME_LEN bytes from an upstream writer into a one-frame buffer, then emits them as a single gap-free burst. It monitors the sorter's returned out_valid stream until the sorted frame has fully drained. After a fixed idle gap, it accepts the next frame.

Parameters:
FRAME_LEN, 10, bytes per frame; range 2..255
GAP_CYC, 2, idle cycles between result drain and next fill; range 1..255
TIMEOUT, 1023, max cycles in WAIT before error; range 1..65535

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
wr_valid  input  1  upstream byte valid
wr_data  input  8  upstream byte
wr_ready  output  1  buffer accepts a byte this cycle
tx_valid  output  1  drives sorter in_valid
tx_data  output  8  drives sorter in_data
rx_valid  input  1  sorter result out_valid, returned for drain tracking
busy  output  1  high in any state other than FILL
frame_cnt  output  8  count of frames completed without error; wraps at 255->0
err  output  1  one-cycle pulse on a bad or missing result

Behaviour:
- Reset: asynchronous assert, synchronous deassert of effect. All outputs go to 0 (wr_ready=0, tx_valid=0, tx_data=0, busy=0, frame_cnt=0, err=0). State goes to FILL with wr_cnt=0.
- Reset mid-burst: tx_valid drops immediately. The partial frame is discarded.
- All outputs are registered. wr_ready is computed combinationally from state and wr_cnt only, never from wr_valid.
- FILL:
  - wr_ready = (wr_cnt < FRAME_LEN).
  - A write occurs when wr_valid and wr_ready are both high: buf[wr_cnt] <= wr_data, and wr_cnt increments.
  - When the FRAME_LEN-th byte is written, the next state is SEND.
  - wr_ready is 0 on the cycle after the last write.
- SEND:
  - tx_valid=1 for exactly FRAME_LEN consecutive cycles.
  - tx_data = buf[0], buf[1], ... in write order.
  - The first tx_valid appears 1 cycle after the last write.
  - No bubbles, and no stalling on any input.
  - After the last byte, tx_valid=0 and tx_data returns to 0. Next state is WAIT.
- WAIT:
  - rx_cnt counts rx_valid cycles and tmo_cnt counts all cycles.
  - Completion is the first falling edge of rx_valid (registered rx_valid=1 and current rx_valid=0) after at least one rx_valid.
  - On completion with rx_cnt==FRAME_LEN: frame_cnt++ and next state is GAP.
  - On completion with rx_cnt!=FRAME_LEN: err=1 for one cycle, frame_cnt unchanged, next state is GAP.
  - If tmo_cnt reaches TIMEOUT before completion: err=1 for one cycle, next state is GAP.
- rx_valid outside WAIT is ignored and counts nothing. This includes rx_valid asserted during SEND.
- GAP: idle for GAP_CYC cycles, then go to FILL with wr_cnt, rx_cnt and tmo_cnt cleared.
- busy = (state != FILL).
- wr_valid in any state other than FILL is not accepted and the data is dropped. Upstream must honour wr_ready.
- Buffer: FRAME_LEN x 8 registers; no reset is required on buffer contents.
- Counter widths: wr_cnt and rx_cnt are 8 bits. tmo_cnt is 16 bits and saturates.

Test Plan:
- Basic frame: write 10 bytes 9,3,7,1,0,8,2,6,5,4 with wr_valid held; model sorter returns 10 rx_valid cycles -> tx_valid high exactly 10 consecutive cycles with tx_data 9,3,7,...,4 in order; frame_cnt=1; err never asserts.
- Upstream throttling: wr_valid toggles 1/0 each cycle -> only accepted bytes are buffered; the burst starts 1 cycle after the 10th accept; wr_ready=0 throughout SEND, WAIT and GAP.
- Short result: model returns 9 rx_valid cycles -> one-cycle err pulse at drain; frame_cnt unchanged; FILL re-entered after 2 GAP cycles.
- Timeout: rx_valid never asserts with TIMEOUT=20 -> err pulse 20 cycles after WAIT entry; busy falls GAP_CYC cycles later.
- Reset mid-SEND: rst_n low after the 4th tx byte -> tx_valid=0 and frame_cnt=0 in the same cycle; after release, FILL with wr_ready=1 and a full new frame transmits correctly.
- Back-to-back frames: 256 frames with correct results -> frame_cnt wraps to 0; gap between result drain and the first new wr_ready is exactly GAP_CYC cycles.
